// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-requester memory port arbiter.
// - Requester IDs stored in the in-order tracking queue.
// - 4-byte memory request/response message layouts.
package mem_port_arbiter_pkg;

  localparam logic MEM_ARB_ID_IMEM = 1'b0;
  localparam logic MEM_ARB_ID_DMEM = 1'b1;

  typedef enum logic [2:0] {
    MEM_MSG_READ  = 3'd0,
    MEM_MSG_WRITE = 3'd1,
    MEM_MSG_INIT  = 3'd2,
    MEM_MSG_AMO   = 3'd3
  } mem_msg_type_e;

  typedef struct packed {
    mem_msg_type_e msg_type;
    logic [7:0]    opaque;
    logic [31:0]   addr;
    logic [1:0]    len;
    logic [31:0]   data;
  } mem_req_4B_t;

  typedef struct packed {
    mem_msg_type_e msg_type;
    logic [7:0]    opaque;
    logic [1:0]    test;
    logic [1:0]    len;
    logic [31:0]   data;
  } mem_resp_4B_t;

endpackage

// File: rtl/mem_arb_id_queue.sv
// In-order 1-bit FIFO holding the requester ID of every outstanding request.
// Ports:
//   clk, reset       clock, synchronous active-high reset (empties the queue)
//   enq_val, enq_id  push request and ID (ignored while full)
//   deq_val          pop request (ignored while empty)
//   deq_id           ID at the head of the queue
//   full, empty      flags derived from the registered occupancy count
module mem_arb_id_queue #(
  parameter int p_depth = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enq_val,
  input  logic enq_id,
  input  logic deq_val,
  output logic deq_id,
  output logic full,
  output logic empty
);

  localparam int c_ptr_w = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int c_cnt_w = $clog2(p_depth) + 1;

  logic                id_mem [p_depth];
  logic [c_ptr_w-1:0]  wr_ptr_reg;
  logic [c_ptr_w-1:0]  rd_ptr_reg;
  logic [c_cnt_w-1:0]  count_reg;
  logic                push;
  logic                pop;

  function automatic logic [c_ptr_w-1:0] next_ptr(input logic [c_ptr_w-1:0] ptr);
    return (ptr == c_ptr_w'(p_depth - 1)) ? '0 : ptr + c_ptr_w'(1);
  endfunction

  // Flags come only from the registered count, so a pop never frees a slot
  // for a push in the same cycle.
  assign full   = (count_reg == c_cnt_w'(p_depth));
  assign empty  = (count_reg == '0);
  assign push   = enq_val && !full;
  assign pop    = deq_val && !empty;
  assign deq_id = id_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + c_cnt_w'(1);
        2'b01:   count_reg <= count_reg - c_cnt_w'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (push && !reset) id_mem[wr_ptr_reg] <= enq_id;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 4B memory port between instruction fetch (port 0, imem) and
// data access (port 1, dmem). Requests are arbitrated round-robin or with
// fixed dmem priority and forwarded combinationally; the winner's ID is
// queued so in-order responses can be steered back to their owner.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   imem_reqstream_*           requester 0 request  (msg/val in, rdy out)
//   imem_respstream_*          requester 0 response (msg/val out, rdy in)
//   dmem_reqstream_*           requester 1 request
//   dmem_respstream_*          requester 1 response
//   mem_reqstream_*            shared request to memory
//   mem_respstream_*           shared response from memory
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int p_num_inflight = 4,
  parameter bit p_round_robin  = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  mem_req_4B_t  imem_reqstream_msg,
  input  logic         imem_reqstream_val,
  output logic         imem_reqstream_rdy,
  output mem_resp_4B_t imem_respstream_msg,
  output logic         imem_respstream_val,
  input  logic         imem_respstream_rdy,
  input  mem_req_4B_t  dmem_reqstream_msg,
  input  logic         dmem_reqstream_val,
  output logic         dmem_reqstream_rdy,
  output mem_resp_4B_t dmem_respstream_msg,
  output logic         dmem_respstream_val,
  input  logic         dmem_respstream_rdy,
  output mem_req_4B_t  mem_reqstream_msg,
  output logic         mem_reqstream_val,
  input  logic         mem_reqstream_rdy,
  input  mem_resp_4B_t mem_respstream_msg,
  input  logic         mem_respstream_val,
  output logic         mem_respstream_rdy
);

  logic [1:0] req_val;
  logic [1:0] req_rdy;
  logic [1:0] resp_val;
  logic [1:0] resp_rdy;
  logic       prio_reg;
  logic       winner;
  logic       grant;
  logic       req_fire;
  logic       resp_fire;
  logic       head_id;
  logic       full;
  logic       empty;

  assign req_val  = {dmem_reqstream_val, imem_reqstream_val};
  assign resp_rdy = {dmem_respstream_rdy, imem_respstream_rdy};

  // With a single candidate both modes pick it; the pointer only matters
  // when both ports are requesting in round-robin mode.
  always_comb begin
    winner = req_val[MEM_ARB_ID_DMEM];
    if (p_round_robin && (&req_val)) winner = prio_reg;
  end

  assign grant             = !reset && (|req_val) && !full;
  assign mem_reqstream_val = grant;
  assign mem_reqstream_msg = (winner == MEM_ARB_ID_DMEM) ? dmem_reqstream_msg
                                                          : imem_reqstream_msg;
  assign req_fire          = grant && mem_reqstream_rdy;

  // Ready to memory depends only on the head owner's ready; req_rdy never
  // sees any resp_rdy input.
  assign mem_respstream_rdy = !reset && !empty && resp_rdy[head_id];
  assign resp_fire          = mem_respstream_val && mem_respstream_rdy;

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign req_rdy[gi]  = grant && (winner == 1'(gi)) && mem_reqstream_rdy;
    assign resp_val[gi] = !reset && !empty && mem_respstream_val && (head_id == 1'(gi));
  end

  assign imem_reqstream_rdy  = req_rdy[MEM_ARB_ID_IMEM];
  assign dmem_reqstream_rdy  = req_rdy[MEM_ARB_ID_DMEM];
  assign imem_respstream_val = resp_val[MEM_ARB_ID_IMEM];
  assign dmem_respstream_val = resp_val[MEM_ARB_ID_DMEM];
  assign imem_respstream_msg = mem_respstream_msg;
  assign dmem_respstream_msg = mem_respstream_msg;

  // Pointer hands priority to the other port after every fire, contended
  // or not.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_reg <= MEM_ARB_ID_IMEM;
    end else if (p_round_robin && req_fire) begin
      prio_reg <= ~winner;
    end
  end

  mem_arb_id_queue #(
    .p_depth (p_num_inflight)
  ) u_id_queue (
    .clk     (clk),
    .reset   (reset),
    .enq_val (req_fire),
    .enq_id  (winner),
    .deq_val (resp_fire),
    .deq_id  (head_id),
    .full    (full),
    .empty   (empty)
  );

  // A response with nothing outstanding means the memory broke ordering.
  assert property (@(posedge clk) disable iff (reset) !(mem_respstream_val && empty));

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // round-robin DUT (depth 4)
  mem_req_4B_t  imem_req_msg, dmem_req_msg, mem_req_msg;
  mem_resp_4B_t imem_resp_msg, dmem_resp_msg, mem_resp_msg;
  logic imem_req_val, imem_req_rdy, imem_resp_val, imem_resp_rdy;
  logic dmem_req_val, dmem_req_rdy, dmem_resp_val, dmem_resp_rdy;
  logic mem_req_val, mem_req_rdy, mem_resp_val, mem_resp_rdy;

  // fixed-priority DUT (depth 4), memory never responds
  mem_req_4B_t  f_imem_req_msg, f_dmem_req_msg, f_mem_req_msg;
  mem_resp_4B_t f_imem_resp_msg, f_dmem_resp_msg, f_mem_resp_msg;
  logic f_imem_req_val, f_imem_req_rdy, f_imem_resp_val;
  logic f_dmem_req_val, f_dmem_req_rdy, f_dmem_resp_val;
  logic f_mem_req_val, f_mem_req_rdy, f_mem_resp_val, f_mem_resp_rdy;

  mem_port_arbiter #(.p_num_inflight(4), .p_round_robin(1'b1)) dut (
    .clk(clk), .reset(reset),
    .imem_reqstream_msg(imem_req_msg), .imem_reqstream_val(imem_req_val),
    .imem_reqstream_rdy(imem_req_rdy), .imem_respstream_msg(imem_resp_msg),
    .imem_respstream_val(imem_resp_val), .imem_respstream_rdy(imem_resp_rdy),
    .dmem_reqstream_msg(dmem_req_msg), .dmem_reqstream_val(dmem_req_val),
    .dmem_reqstream_rdy(dmem_req_rdy), .dmem_respstream_msg(dmem_resp_msg),
    .dmem_respstream_val(dmem_resp_val), .dmem_respstream_rdy(dmem_resp_rdy),
    .mem_reqstream_msg(mem_req_msg), .mem_reqstream_val(mem_req_val),
    .mem_reqstream_rdy(mem_req_rdy), .mem_respstream_msg(mem_resp_msg),
    .mem_respstream_val(mem_resp_val), .mem_respstream_rdy(mem_resp_rdy)
  );

  mem_port_arbiter #(.p_num_inflight(4), .p_round_robin(1'b0)) dut_fixed (
    .clk(clk), .reset(reset),
    .imem_reqstream_msg(f_imem_req_msg), .imem_reqstream_val(f_imem_req_val),
    .imem_reqstream_rdy(f_imem_req_rdy), .imem_respstream_msg(f_imem_resp_msg),
    .imem_respstream_val(f_imem_resp_val), .imem_respstream_rdy(1'b0),
    .dmem_reqstream_msg(f_dmem_req_msg), .dmem_reqstream_val(f_dmem_req_val),
    .dmem_reqstream_rdy(f_dmem_req_rdy), .dmem_respstream_msg(f_dmem_resp_msg),
    .dmem_respstream_val(f_dmem_resp_val), .dmem_respstream_rdy(1'b0),
    .mem_reqstream_msg(f_mem_req_msg), .mem_reqstream_val(f_mem_req_val),
    .mem_reqstream_rdy(f_mem_req_rdy), .mem_respstream_msg(f_mem_resp_msg),
    .mem_respstream_val(f_mem_resp_val), .mem_respstream_rdy(f_mem_resp_rdy)
  );

  // Memory model: latency 1, in order, data = ~addr, opaque echoed.
  mem_resp_4B_t mbuf [16];
  logic [3:0]   mhead, mtail;
  logic         mem_en;

  function automatic mem_resp_4B_t mk_resp(input mem_req_4B_t r);
    mem_resp_4B_t s;
    s.msg_type = r.msg_type;
    s.opaque   = r.opaque;
    s.test     = 2'd0;
    s.len      = r.len;
    s.data     = ~r.addr;
    return s;
  endfunction

  function automatic mem_req_4B_t mk_req(input logic [31:0] addr, input logic [7:0] opq);
    mem_req_4B_t r;
    r.msg_type = MEM_MSG_READ;
    r.opaque   = opq;
    r.addr     = addr;
    r.len      = 2'd0;
    r.data     = 32'd0;
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mhead <= 4'd0;
      mtail <= 4'd0;
    end else begin
      if (mem_resp_val && mem_resp_rdy) mhead <= mhead + 4'd1;
      if (mem_req_val && mem_req_rdy) begin
        mbuf[mtail] <= mk_resp(mem_req_msg);
        mtail       <= mtail + 4'd1;
      end
    end
  end

  assign mem_resp_val = mem_en && (mhead != mtail);
  assign mem_resp_msg = mbuf[mhead];

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-16s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    imem_req_val = 1'b0;
    dmem_req_val = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    mem_req_4B_t imsg, dmsg, r200, r104;
    imsg = mk_req(32'h100, 8'h01);
    dmsg = mk_req(32'h800, 8'h02);
    r200 = mk_req(32'h200, 8'h11);
    r104 = mk_req(32'h104, 8'h21);

    reset = 1'b1;
    imem_req_msg = imsg;  dmem_req_msg = dmsg;
    imem_req_val = 1'b1;  dmem_req_val = 1'b1;
    imem_resp_rdy = 1'b1; dmem_resp_rdy = 1'b1;
    mem_req_rdy = 1'b1;   mem_en = 1'b1;
    f_imem_req_msg = imsg; f_dmem_req_msg = dmsg;
    f_imem_req_val = 1'b1; f_dmem_req_val = 1'b1;
    f_mem_req_rdy = 1'b1;  f_mem_resp_val = 1'b0;
    f_mem_resp_msg = '0;

    // reset: every val/rdy output low even with requests pending
    @(negedge clk); @(negedge clk); #1;
    check("rst_outs", {imem_req_rdy, dmem_req_rdy, imem_resp_val, dmem_resp_val,
                       mem_req_val, mem_resp_rdy}, 6'b0);
    check("rst_outs_fixed", {f_imem_req_rdy, f_dmem_req_rdy, f_imem_resp_val,
                             f_dmem_resp_val, f_mem_req_val, f_mem_resp_rdy}, 6'b0);

    // fixed priority: dmem wins while valid, imem only when dmem idle
    @(negedge clk);
    reset = 1'b0;
    imem_req_val = 1'b0; dmem_req_val = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("fix_addr", f_mem_req_msg.addr, 32'h800);
      check("fix_rdy", {f_dmem_req_rdy, f_imem_req_rdy}, 2'b10);
      @(negedge clk);
    end
    f_dmem_req_val = 1'b0;
    #1;
    check("fix_imem_addr", f_mem_req_msg.addr, 32'h100);
    check("fix_imem_rdy", {f_mem_req_val, f_dmem_req_rdy, f_imem_req_rdy}, 3'b101);
    @(negedge clk); #1;
    check("fix_full", {f_mem_req_val, f_imem_req_rdy}, 2'b00);
    f_imem_req_val = 1'b0;

    // single imem read to 0x200, latency 1
    @(negedge clk);
    imem_req_msg = r200; imem_req_val = 1'b1;
    #1;
    check("t1_req_val", mem_req_val, 1'b1);
    check("t1_req_msg", mem_req_msg, r200);
    check("t1_req_rdy", {dmem_req_rdy, imem_req_rdy}, 2'b01);
    @(negedge clk);
    imem_req_val = 1'b0;
    #1;
    check("t1_resp_val", {dmem_resp_val, imem_resp_val}, 2'b01);
    check("t1_resp_data", imem_resp_msg.data, 32'hFFFF_FDFF);
    check("t1_resp_opq", imem_resp_msg.opaque, 8'h11);
    @(negedge clk); #1;
    check("t1_drained", {imem_resp_val, mem_resp_rdy}, 2'b00);

    // round-robin, both valid: I,D,I,D with responses one cycle behind
    do_reset();
    imem_req_msg = imsg; dmem_req_msg = dmsg;
    imem_req_val = 1'b1; dmem_req_val = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_addr", mem_req_msg.addr, (k % 2 == 1) ? 32'h800 : 32'h100);
      check("rr_rdy", {dmem_req_rdy, imem_req_rdy}, (k % 2 == 1) ? 2'b10 : 2'b01);
      if (k > 0) begin
        check("rr_resp_val", {dmem_resp_val, imem_resp_val}, (k % 2 == 1) ? 2'b01 : 2'b10);
        check("rr_resp_data", imem_resp_msg.data,
              (k % 2 == 1) ? 32'hFFFF_FEFF : 32'hFFFF_F7FF);
      end
      @(negedge clk);
    end
    imem_req_val = 1'b0; dmem_req_val = 1'b0;
    #1;
    check("rr_last_resp", {dmem_resp_val, imem_resp_val}, 2'b10);
    @(negedge clk); #1;
    check("rr_idle", {dmem_resp_val, imem_resp_val}, 2'b00);

    // memory stalled: 4 fire, then blocked; released pop frees slot next cycle
    do_reset();
    mem_en = 1'b0;
    imem_req_val = 1'b1; dmem_req_val = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("st_fire", mem_req_val, 1'b1);
      @(negedge clk);
    end
    #1;
    check("st_full", {mem_req_val, imem_req_rdy, dmem_req_rdy}, 3'b000);
    mem_en = 1'b1;
    #1;
    check("st_pop_rdy", {mem_resp_rdy, imem_resp_val}, 2'b11);
    check("st_no_bypass", mem_req_val, 1'b0);
    @(negedge clk);
    mem_en = 1'b0;
    #1;
    check("st_after_pop", {mem_req_val, imem_req_rdy}, 2'b11);
    imem_req_val = 1'b0; dmem_req_val = 1'b0;
    mem_en = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("st_drained", {mem_resp_val, mem_resp_rdy}, 2'b00);

    // head port not ready: nothing popped, other port sees nothing
    do_reset();
    imem_resp_rdy = 1'b0;
    imem_req_msg = r104; imem_req_val = 1'b1;
    @(negedge clk);
    imem_req_val = 1'b0;
    #1;
    check("hd_val", {dmem_resp_val, imem_resp_val, mem_resp_rdy}, 3'b010);
    @(negedge clk); #1;
    check("hd_held", {dmem_resp_val, imem_resp_val, mem_resp_rdy}, 3'b010);
    imem_resp_rdy = 1'b1;
    #1;
    check("hd_release", mem_resp_rdy, 1'b1);
    check("hd_data", imem_resp_msg.data, 32'hFFFF_FEFB);
    @(negedge clk); #1;
    check("hd_popped", imem_resp_val, 1'b0);

    // reset with 3 in flight discards them
    do_reset();
    mem_en = 1'b0;
    imem_req_msg = imsg; imem_req_val = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1; dmem_req_val = 1'b1; mem_en = 1'b1;
    @(negedge clk); #1;
    check("mr_outs", {imem_req_rdy, dmem_req_rdy, imem_resp_val, dmem_resp_val,
                      mem_req_val, mem_resp_rdy}, 6'b0);
    reset = 1'b0; dmem_req_val = 1'b0;
    #1;
    check("mr_grant", {mem_req_val, imem_req_rdy, imem_resp_val}, 3'b110);
    @(negedge clk);
    mem_en = 1'b0;
    for (int k = 1; k < 4; k++) begin
      #1;
      check("mr_room", mem_req_val, 1'b1);
      @(negedge clk);
    end
    #1;
    check("mr_full_at_4", mem_req_val, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one 4B memory request/response port between two requesters: port 0 = instruction fetch, port 1 = data access.
- Sits between the processor's imem/dmem streams and a single memory, or a unified cache, in the lab3 system.
- Arbitrates requests round-robin, or with fixed priority when configured.
- Records the requester ID of each granted request in an in-order tracking queue, then steers each response back to its owner.
- Memory must return responses in request order. Opaque fields pass through unmodified.

Parameters:
p_num_inflight  4  max outstanding requests (tracking-queue depth); power of 2, ≥1
p_round_robin  1  1 = round-robin arbitration; 0 = fixed priority, port 1 (dmem) wins

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
imem_reqstream_msg  input  $bits(mem_req_4B_t)  requester 0 request
imem_reqstream_val  input  1  requester 0 request valid
imem_reqstream_rdy  output  1  requester 0 request ready
imem_respstream_msg  output  $bits(mem_resp_4B_t)  requester 0 response
imem_respstream_val  output  1  requester 0 response valid
imem_respstream_rdy  input  1  requester 0 response ready
dmem_reqstream_msg/val/rdy  in/in/out  same as imem  requester 1 request
dmem_respstream_msg/val/rdy  out/out/in  same as imem  requester 1 response
mem_reqstream_msg  output  $bits(mem_req_4B_t)  shared request
mem_reqstream_val  output  1  shared request valid
mem_reqstream_rdy  input  1  shared request ready
mem_respstream_msg  input  $bits(mem_resp_4B_t)  shared response
mem_respstream_val  input  1  shared response valid
mem_respstream_rdy  output  1  shared response ready

Behaviour:
- Reset: tracking queue empty (count = 0); priority pointer = port 0. While reset is high, every val/rdy output is 0.
- Arbitration (combinational):
  - Candidates are the ports with req_val = 1.
  - Round-robin: if both are valid, the port equal to the priority pointer wins. Fixed mode: port 1 wins.
- Grant condition: winner exists and tracking queue is not full.
  - mem_reqstream_val = grant.
  - mem_reqstream_msg = winner's msg, bit-exact.
  - Winner's req_rdy = mem_reqstream_rdy && !full. The loser's req_rdy = 0.
- Request fire (mem_reqstream_val && mem_reqstream_rdy):
  - Push the winner ID into the tracking queue.
  - Round-robin mode: pointer ← the other port, regardless of contention.
  - No fire → pointer holds.
- Request latency: zero-cycle combinational path, no request buffering.
- Response routing, with head = ID at the tracking-queue head:
  - mem_respstream_val is steered only to port head's resp_val.
  - Both resp_msg outputs = mem_respstream_msg. The other port's resp_val = 0.
  - mem_respstream_rdy = head port's resp_rdy && !empty.
- Response fire (mem_respstream_val && mem_respstream_rdy): pop the head.
- Full/empty boundaries:
  - Full is evaluated on the registered count. A pop in the same cycle does not enable a push (no full-bypass).
  - Empty: mem_respstream_rdy = 0. A response valid while empty is a protocol error; the simulation-only assertion fires.
- Push and pop in the same cycle (not full, not empty): count unchanged; pointers advance.
- Wrap-around: read/write pointers are clog2(p_num_inflight) bits wide and wrap naturally. Count is clog2(p_num_inflight)+1 bits.
- No combinational path from any resp_rdy input to any req_rdy output.
- Reset mid-operation: in-flight IDs are discarded. The environment must also reset the memory.
- Line trace: grant port ("I"/"D"/" ") and count.

Decomposition:
- Shared package constants: MEM_ARB_ID_IMEM = 1'b0, MEM_ARB_ID_DMEM = 1'b1.
- Message types: existing mem_req_4B_t / mem_resp_4B_t from vc/mem-msgs.v.
- One sub-module, mem_arb_id_queue: an in-order 1-bit-wide FIFO with full/empty flags, parameterized by depth.
- Arbitration and steering stay in the top-level module.

Test Plan:
- Single imem read to addr 0x200, memory latency 1 → imem response data returned on the imem port; dmem_respstream_val stays 0; count returns to 0.
- Both ports valid every cycle, round-robin → grants alternate I,D,I,D starting with I after reset; each port receives only its own responses in order.
- p_round_robin = 0, both valid → dmem granted every cycle; imem granted only when dmem_reqstream_val = 0.
- Memory resp stalled, p_num_inflight = 4 → exactly 4 requests fire, then mem_reqstream_val = 0 with both req_rdy = 0.
  - Release one response → the push is accepted the following cycle, not the same cycle.
- Head port resp_rdy = 0 with the other port ready → mem_respstream_rdy = 0, no pop, the other port receives nothing.
- Reset asserted with 3 in flight → next cycle all val/rdy outputs = 0, count = 0; a new imem request is granted after reset deasserts.
